func_lut_unit: RTL and testbench

FUNC_LUT_UNIT -- requirements
Module: func_lut_unit

---
 rtl/func_lut_pkg.sv | 17 +
 rtl/func_lut_unit_loader.sv | 87 ++++++++
 rtl/func_lut_unit.sv | 94 +++++++++
 tb/tb_func_lut_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/func_lut_pkg.sv
// Shared types and constants for the func_lut_unit block (optional feature macro: FUNC_LUT_INV_EN).
package func_lut_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SWAP = 2'd2
  } load_state_e;

  localparam int MAX_TBL_W = 256;
  localparam logic [MAX_TBL_W-1:0] DEFAULT_INIT_TABLE = 256'h208E;

  function automatic int num_words(input int n_in, input int cfg_w);
    return (1 << n_in) / cfg_w;
  endfunction

endpackage

// File: rtl/func_lut_unit_loader.sv
// Table-load stream: IDLE/LOAD/SWAP FSM, word counter and shadow truth table.
module func_lut_loader
  import func_lut_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int CFG_W = 8,
  parameter logic [(1<<N_IN)-1:0] INIT_TABLE = DEFAULT_INIT_TABLE[(1<<N_IN)-1:0]
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid_i,
  input  logic [CFG_W-1:0]     cfg_data_i,
  output logic                 cfg_ready_o,
  output logic                 cfg_busy_o,
  output logic                 swap_o,
  output logic [(1<<N_IN)-1:0] shadow_o
);

  localparam int NW = num_words(N_IN, CFG_W);
  localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NW - 1);

  load_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             word_acc;

  assign word_acc = cfg_valid_i & cfg_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_ready_o = 1'b1;
    cfg_busy_o  = 1'b0;
    swap_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (word_acc) begin
          cnt_d   = cnt_q + CNT_W'(1);
          // A single-word table skips LOAD entirely.
          state_d = (cnt_q == LAST_WORD) ? SWAP : LOAD;
        end
      end
      LOAD: begin
        cfg_busy_o = 1'b1;
        if (word_acc) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_WORD) state_d = SWAP;
        end
      end
      SWAP: begin
        cfg_ready_o = 1'b0;
        cfg_busy_o  = 1'b1;
        swap_o      = 1'b1;
        cnt_d       = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_word
      logic [CFG_W-1:0] word_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_q <= INIT_TABLE[gi*CFG_W +: CFG_W];
        end else if (word_acc && (cnt_q == CNT_W'(gi))) begin
          word_q <= cfg_data_i;
        end
      end

      assign shadow_o[gi*CFG_W +: CFG_W] = word_q;
    end
  endgenerate

endmodule

// File: rtl/func_lut_unit.sv
// Registered truth-table evaluator with atomic double-buffered table reload.
// Optional FUNC_LUT_INV_EN adds inv_sel, which inverts the registered result.
module func_lut_unit
  import func_lut_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int CFG_W = 8,
  parameter logic [(1<<N_IN)-1:0] INIT_TABLE = DEFAULT_INIT_TABLE[(1<<N_IN)-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
`ifdef FUNC_LUT_INV_EN
  input  logic             inv_sel,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_busy
);

  localparam int TBL_W = 1 << N_IN;

  logic [TBL_W-1:0] active_q;
  logic [TBL_W-1:0] shadow;
  logic             swap;
  logic             out_valid_q, out_valid_d;
  logic             out_data_q, out_data_d;
  logic             in_acc;
  logic             eval_bit;

  func_lut_loader #(
    .N_IN      (N_IN),
    .CFG_W     (CFG_W),
    .INIT_TABLE(INIT_TABLE)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid_i(cfg_valid),
    .cfg_data_i (cfg_data),
    .cfg_ready_o(cfg_ready),
    .cfg_busy_o (cfg_busy),
    .swap_o     (swap),
    .shadow_o   (shadow)
  );

  // The active table only changes at the end of SWAP, so the SWAP-cycle operand sees the old one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= INIT_TABLE;
    end else if (swap) begin
      active_q <= shadow;
    end
  end

`ifdef FUNC_LUT_INV_EN
  assign eval_bit = active_q[in_data] ^ inv_sel;
`else
  assign eval_bit = active_q[in_data];
`endif

  assign in_ready = ~out_valid_q | out_ready;
  assign in_acc   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = eval_bit;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_func_lut_unit.sv
// Self-checking bench for func_lut_unit: default 4-input/8-bit-load instance plus a 6-input single-word instance.
module tb_func_lut_unit;

  localparam logic [15:0] TBL0 = 16'h208E;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_data;
  logic       cfg_valid, cfg_ready, cfg_busy;
  logic [3:0] in_data;
  logic [7:0] cfg_data;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, out_data64;
  logic        cfg_valid64, cfg_ready64, cfg_busy64;
  logic [5:0]  in_data64;
  logic [63:0] cfg_data64;

`ifdef FUNC_LUT_INV_EN
  logic inv_sel, inv_sel64;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  func_lut_unit u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef FUNC_LUT_INV_EN
    .inv_sel  (inv_sel),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_data (cfg_data),
    .cfg_busy (cfg_busy)
  );

  func_lut_unit #(.N_IN(6), .CFG_W(64)) u_dut64 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid64),
    .in_ready (in_ready64),
    .in_data  (in_data64),
`ifdef FUNC_LUT_INV_EN
    .inv_sel  (inv_sel64),
`endif
    .out_valid(out_valid64),
    .out_ready(out_ready64),
    .out_data (out_data64),
    .cfg_valid(cfg_valid64),
    .cfg_ready(cfg_ready64),
    .cfg_data (cfg_data64),
    .cfg_busy (cfg_busy64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 1'b0) begin n_fail++; $display("FAIL reset_out_data got %b want 0", out_data); end
    n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_busy got %b want 0", cfg_busy); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    n_checks++; if (cfg_busy64 !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_busy64 got %b want 0", cfg_busy64); end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid got %b want 0", out_valid); end
    $display("reset released");
  endtask

  task automatic test_sweep();
    logic exp;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 4'(i);
      tick();
      exp = (i == 1) || (i == 2) || (i == 3) || (i == 7) || (i == 13);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        n_fail++;
        $display("FAIL sweep[%0d] got valid=%b data=%b want valid=1 data=%b", i, out_valid, out_data, exp);
      end
      $display("sweep in_data=%0d out_data=%b", i, out_data);
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_drain got valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] tbl;
    logic [3:0]  a, b;
    tbl = TBL0;
    a = 4'd13;
    case ($urandom_range(0, 4))
      0: a = 4'd1;
      1: a = 4'd2;
      2: a = 4'd3;
      3: a = 4'd7;
      default: a = 4'd13;
    endcase
    b = 4'($urandom_range(0, 15));
    while (tbl[b] == 1'b1) b = 4'($urandom_range(0, 15));

    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = a;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 1'b1) begin n_fail++; $display("FAIL bp_first got valid=%b data=%b want 1/1", out_valid, out_data); end
    out_ready = 1'b0;
    in_data   = b;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got valid=%b data=%b in_ready=%b want 1/1/0", c, out_valid, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 1'b0) begin n_fail++; $display("FAIL bp_second got valid=%b data=%b want 1/0", out_valid, out_data); end
    $display("backpressure a=%0d b=%0d out_data=%b", a, b, out_data);
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got valid=%b want 0", out_valid); end
  endtask

  task automatic test_load();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'd5;
    cfg_valid = 1'b0;
    tick();
    n_checks++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL load_pre_busy got %b want 0", cfg_busy); end
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    tick();
    n_checks++; if (out_data !== 1'b0 || cfg_busy !== 1'b1 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL load_w0 got data=%b busy=%b ready=%b want 0/1/1", out_data, cfg_busy, cfg_ready); end
    cfg_data = 8'h00;
    tick();
    cfg_valid = 1'b0;
    n_checks++; if (out_data !== 1'b0 || cfg_busy !== 1'b1 || cfg_ready !== 1'b0) begin n_fail++; $display("FAIL load_w1 got data=%b busy=%b ready=%b want 0/1/0", out_data, cfg_busy, cfg_ready); end
    tick();
    n_checks++; if (out_data !== 1'b0 || cfg_busy !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++; $display("FAIL load_swap_op got data=%b busy=%b ready=%b want 0/0/1", out_data, cfg_busy, cfg_ready); end
    tick();
    n_checks++; if (out_data !== 1'b1) begin n_fail++; $display("FAIL load_new_table got data=%b want 1", out_data); end
    $display("load FF,00 applied, in_data=5 -> %b", out_data);
    for (int i = 0; i < 16; i++) begin
      in_data = 4'(i);
      tick();
      n_checks++;
      if (out_data !== (i < 8)) begin n_fail++; $display("FAIL load_table[%0d] got %b want %b", i, out_data, (i < 8)); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midload();
    logic [15:0] tbl;
    tbl = TBL0;
    out_ready = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'h00;
    tick();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL midload_busy got %b want 1", cfg_busy); end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'd13;
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midload_pending got valid=%b want 1", out_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || cfg_busy !== 1'b0) begin n_fail++; $display("FAIL midload_async_rst got valid=%b busy=%b want 0/0", out_valid, cfg_busy); end
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || cfg_busy !== 1'b0) begin n_fail++; $display("FAIL midload_after_rst got valid=%b busy=%b want 0/0", out_valid, cfg_busy); end
    in_valid = 1'b1;
    in_data  = 4'd13;
    tick();
    n_checks++; if (out_data !== 1'b1) begin n_fail++; $display("FAIL midload_in13 got %b want 1", out_data); end
    for (int i = 0; i < 16; i++) begin
      in_data = 4'(i);
      tick();
      n_checks++;
      if (out_data !== tbl[i]) begin n_fail++; $display("FAIL midload_table[%0d] got %b want %b", i, out_data, tbl[i]); end
    end
    $display("reset mid-load: table reverted");
    in_valid = 1'b0;
    tick();
  endtask

`ifdef FUNC_LUT_INV_EN
  task automatic test_inv();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inv_sel   = 1'b1;
    in_data   = 4'd13;
    tick();
    n_checks++; if (out_data !== 1'b0) begin n_fail++; $display("FAIL inv_13 got %b want 0", out_data); end
    in_data = 4'd0;
    tick();
    n_checks++; if (out_data !== 1'b1) begin n_fail++; $display("FAIL inv_0 got %b want 1", out_data); end
    $display("inv_sel checks done");
    inv_sel  = 1'b0;
    in_valid = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    logic [15:0] tbl_cur;
    logic [7:0]  words [2];
    int          words_got;
    logic        swap_cycle, nxt_swap, exp_in_ready, inv_b;
    logic        exp_q [$];
    int          n_txn;
    tbl_cur    = TBL0;
    words[0]   = 8'h00;
    words[1]   = 8'h00;
    words_got  = 0;
    swap_cycle = 1'b0;
    n_txn      = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_data  = 8'($urandom);
`ifdef FUNC_LUT_INV_EN
      inv_b   = 1'($urandom_range(0, 1));
      inv_sel = inv_b;
`else
      inv_b = 1'b0;
`endif
      #1;
      n_checks++; if (out_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", c, out_valid, (exp_q.size() != 0)); end
      if (exp_q.size() != 0) begin
        n_checks++; if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL rnd_data[%0d] got %b want %b", c, out_data, exp_q[0]); end
      end
      exp_in_ready = (exp_q.size() == 0) || out_ready;
      n_checks++; if (in_ready !== exp_in_ready) begin n_fail++; $display("FAIL rnd_in_ready[%0d] got %b want %b", c, in_ready, exp_in_ready); end
      n_checks++; if (cfg_ready !== !swap_cycle || cfg_busy !== ((words_got != 0) || swap_cycle)) begin
        n_fail++; $display("FAIL rnd_cfg[%0d] got ready=%b busy=%b want %b/%b", c, cfg_ready, cfg_busy, !swap_cycle, ((words_got != 0) || swap_cycle));
      end
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        n_txn++;
      end
      if (in_valid && exp_in_ready) exp_q.push_back(tbl_cur[in_data] ^ inv_b);
      nxt_swap = 1'b0;
      if (cfg_valid && !swap_cycle) begin
        words[words_got] = cfg_data;
        if (words_got == 1) begin
          words_got = 0;
          nxt_swap  = 1'b1;
        end else begin
          words_got = 1;
        end
      end
      if (swap_cycle) tbl_cur = {words[1], words[0]};
      swap_cycle = nxt_swap;
      @(posedge clk);
      #1;
    end
    $display("random stream: %0d results taken, final table %h", n_txn, tbl_cur);
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
`ifdef FUNC_LUT_INV_EN
    inv_sel = 1'b0;
`endif
  endtask

  task automatic test_single_word64();
    logic [63:0] tbl_old, data;
    logic [5:0]  idx, idx2;
    tbl_old = 64'h208E;
    data    = {$urandom, $urandom};
    idx     = 6'($urandom_range(0, 63));
    data[idx] = ~tbl_old[idx];
    out_ready64 = 1'b1;
    in_valid64  = 1'b1;
    in_data64   = idx;
    cfg_valid64 = 1'b0;
    tick();
    n_checks++; if (cfg_ready64 !== 1'b1 || cfg_busy64 !== 1'b0 || out_data64 !== tbl_old[idx]) begin
      n_fail++; $display("FAIL sw64_pre got ready=%b busy=%b data=%b want 1/0/%b", cfg_ready64, cfg_busy64, out_data64, tbl_old[idx]);
    end
    cfg_valid64 = 1'b1;
    cfg_data64  = data;
    tick();
    cfg_valid64 = 1'b0;
    n_checks++; if (cfg_ready64 !== 1'b0 || cfg_busy64 !== 1'b1 || out_data64 !== tbl_old[idx]) begin
      n_fail++; $display("FAIL sw64_swap got ready=%b busy=%b data=%b want 0/1/%b", cfg_ready64, cfg_busy64, out_data64, tbl_old[idx]);
    end
    tick();
    n_checks++; if (cfg_ready64 !== 1'b1 || cfg_busy64 !== 1'b0 || out_data64 !== tbl_old[idx]) begin
      n_fail++; $display("FAIL sw64_idle got ready=%b busy=%b data=%b want 1/0/%b", cfg_ready64, cfg_busy64, out_data64, tbl_old[idx]);
    end
    tick();
    n_checks++; if (out_data64 !== data[idx]) begin n_fail++; $display("FAIL sw64_new[%0d] got %b want %b", idx, out_data64, data[idx]); end
    for (int k = 0; k < 8; k++) begin
      idx2 = 6'($urandom_range(0, 63));
      in_data64 = idx2;
      tick();
      n_checks++; if (out_data64 !== data[idx2]) begin n_fail++; $display("FAIL sw64_tbl[%0d] got %b want %b", idx2, out_data64, data[idx2]); end
    end
    $display("single-word load of %h done", data);
    in_valid64 = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0;
    in_valid64 = 1'b0; in_data64 = '0; out_ready64 = 1'b0;
    cfg_valid64 = 1'b0; cfg_data64 = '0;
`ifdef FUNC_LUT_INV_EN
    inv_sel = 1'b0;
    inv_sel64 = 1'b0;
`endif
    #1;
    test_reset();
    test_sweep();
    test_backpressure();
    test_load();
    test_reset_midload();
`ifdef FUNC_LUT_INV_EN
    test_inv();
`endif
    test_random();
    test_single_word64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
